// File: rtl/ex_muldiv.sv
// ---------------------------------------------------------------------------
// ex_muldiv -- iterative RV32M multiply/divide execution unit
//
// Sits behind the decode stage. An OP-opcode instruction with funct7 =
// 0000001 is accepted while the unit is idle. Its operands are sampled once
// at acceptance. The result is produced after a fixed iterative computation
// of one bit per cycle. The pipeline is held through o_busy while the unit
// computes. A jump flush abandons the operation without write-back.
//
// Build option:
//   MULDIV_DIV_EN  defined   : all eight funct3 encodings are executed.
//                  undefined : only MUL/MULH/MULHSU/MULHU are executed.
//                              funct3[2]=1 instructions are ignored, and the
//                              divider datapath is not built.
//
// Ports:
//   i_clk           core clock, rising edge
//   i_rst           asynchronous active-high reset
//   i_inst          instruction word (opcode [6:0], funct3 [14:12], funct7 [31:25])
//   i_op1 / i_op2   rs1 / rs2 values, sampled only at acceptance
//   i_reg_wr_addr   destination register, latched at acceptance
//   i_ex_jump_flag  flush request, aborts an in-flight operation
//   o_busy          pipeline hold request
//   o_valid         one-cycle result strobe
//   o_result        write-back data, meaningful while o_valid = 1
//   o_reg_we        register write enable (same as o_valid)
//   o_reg_wr_addr   latched destination register
// ---------------------------------------------------------------------------
module ex_muldiv (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_op1,
  input  logic [31:0] i_op2,
  input  logic [5:0]  i_reg_wr_addr,
  input  logic        i_ex_jump_flag,
  output logic        o_busy,
  output logic        o_valid,
  output logic [31:0] o_result,
  output logic        o_reg_we,
  output logic [5:0]  o_reg_wr_addr
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
`ifdef MULDIV_DIV_EN
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;
`endif
  localparam logic [4:0] CNT_LAST  = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [31:0] f_neg32(input logic [31:0] v);
    f_neg32 = ~v + 32'd1;
  endfunction

  function automatic logic [63:0] f_neg64(input logic [63:0] v);
    f_neg64 = ~v + 64'd1;
  endfunction

  // 0x80000000 maps onto itself, which is the correct unsigned magnitude 2^31.
  function automatic logic [31:0] f_abs32(input logic [31:0] v);
    if (v[31]) begin
      f_abs32 = f_neg32(v);
    end else begin
      f_abs32 = v;
    end
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_funct3;
  logic        r_sign;
  logic [4:0]  r_cnt;
  // Multiply: [63:32] running partial product, [31:0] multiplier shifting out.
  // Divide:   [31:0] dividend shifting out / quotient shifting in.
  logic [63:0] r_acc;
  // Multiplicand or divisor magnitude.
  logic [31:0] r_mcand;
  logic [31:0] r_result;
  logic [5:0]  r_reg_wr_addr;

  logic [2:0]  w_funct3;
  logic        w_is_muldiv;
  logic        w_start;
  logic [31:0] w_op_a;
  logic [31:0] w_op_b;
  logic        w_op_sign;
  logic        w_special;
  logic [31:0] w_special_result;
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_acc;
  logic [63:0] w_acc_step;
  logic [63:0] w_prod;
  logic [31:0] w_final_result;
  logic        w_unused;

`ifdef MULDIV_DIV_EN
  logic [32:0] r_rem;
  logic [32:0] w_div_shift;
  logic [32:0] w_div_trial;
  logic [32:0] w_div_rem_nxt;
  logic [31:0] w_div_quot_nxt;
`endif

  assign w_funct3    = i_inst[14:12];
  assign w_is_muldiv = (i_inst[6:0] == OPC_OP) && (i_inst[31:25] == F7_MULDIV);

  // Acceptance is also blocked while reset is held, so o_busy reads 0 in reset.
`ifdef MULDIV_DIV_EN
  assign w_start = w_is_muldiv && (r_state == S_IDLE) && !i_ex_jump_flag && !i_rst;
`else
  assign w_start = w_is_muldiv && (w_funct3[2] == 1'b0) && (r_state == S_IDLE) &&
                   !i_ex_jump_flag && !i_rst;
`endif

  assign o_busy        = w_start || (r_state == S_CALC);
  // A flush arriving in the DONE cycle suppresses the write-back as well.
  assign o_valid       = (r_state == S_DONE) && !i_ex_jump_flag;
  assign o_reg_we      = o_valid;
  assign o_result      = r_result;
  assign o_reg_wr_addr = r_reg_wr_addr;

  // Operand conditioning at acceptance: signed operands become magnitudes and
  // the sign of the final result is recorded.
  always_comb begin
    w_op_a    = i_op1;
    w_op_b    = i_op2;
    w_op_sign = 1'b0;
    case (w_funct3)
      F3_MULH: begin
        w_op_a    = f_abs32(i_op1);
        w_op_b    = f_abs32(i_op2);
        w_op_sign = i_op1[31] ^ i_op2[31];
      end
      F3_MULHSU: begin
        w_op_a    = f_abs32(i_op1);
        w_op_b    = i_op2;
        w_op_sign = i_op1[31];
      end
`ifdef MULDIV_DIV_EN
      F3_DIV: begin
        w_op_a    = f_abs32(i_op1);
        w_op_b    = f_abs32(i_op2);
        w_op_sign = i_op1[31] ^ i_op2[31];
      end
      F3_REM: begin
        w_op_a    = f_abs32(i_op1);
        w_op_b    = f_abs32(i_op2);
        w_op_sign = i_op1[31];
      end
`endif
      // MUL's low word is sign-agnostic, so it shares the unsigned path.
      default: begin
        w_op_a    = i_op1;
        w_op_b    = i_op2;
        w_op_sign = 1'b0;
      end
    endcase
  end

`ifdef MULDIV_DIV_EN
  // Division special cases resolved at acceptance without iterating.
  always_comb begin
    w_special        = 1'b0;
    w_special_result = 32'd0;
    if (w_funct3[2] == 1'b1) begin
      if (i_op2 == 32'd0) begin
        w_special = 1'b1;
        if (w_funct3[1] == 1'b1) begin
          w_special_result = i_op1;
        end else begin
          w_special_result = 32'hFFFF_FFFF;
        end
      end else if ((w_funct3[0] == 1'b0) && (i_op1 == 32'h8000_0000) &&
                   (i_op2 == 32'hFFFF_FFFF)) begin
        w_special = 1'b1;
        if (w_funct3[1] == 1'b1) begin
          w_special_result = 32'd0;
        end else begin
          w_special_result = 32'h8000_0000;
        end
      end else begin
        w_special        = 1'b0;
        w_special_result = 32'd0;
      end
    end else begin
      w_special        = 1'b0;
      w_special_result = 32'd0;
    end
  end

  // One restoring-division step: shift in the next dividend bit, try the subtract.
  always_comb begin
    w_div_shift = {r_rem[31:0], r_acc[31]};
    w_div_trial = w_div_shift - {1'b0, r_mcand};
    if (w_div_trial[32] == 1'b0) begin
      w_div_rem_nxt  = w_div_trial;
      w_div_quot_nxt = {r_acc[30:0], 1'b1};
    end else begin
      w_div_rem_nxt  = w_div_shift;
      w_div_quot_nxt = {r_acc[30:0], 1'b0};
    end
  end

  assign w_unused = &{1'b0, i_inst[24:15], i_inst[11:7], r_rem[32], w_div_rem_nxt[32]};
`else
  assign w_special        = 1'b0;
  assign w_special_result = 32'd0;
  assign w_unused         = &{1'b0, i_inst[24:15], i_inst[11:7]};
`endif

  // One shift-add multiply step: conditionally add the multiplicand to the high
  // half, then shift the whole accumulator right, keeping the carry.
  always_comb begin
    if (r_acc[0] == 1'b1) begin
      w_mul_sum = {1'b0, r_acc[63:32]} + {1'b0, r_mcand};
    end else begin
      w_mul_sum = {1'b0, r_acc[63:32]};
    end
    w_mul_acc = {w_mul_sum, r_acc[31:1]};
  end

  // Accumulator value after the current iteration, for whichever unit is active.
  always_comb begin
`ifdef MULDIV_DIV_EN
    if (r_funct3[2] == 1'b1) begin
      w_acc_step = {r_acc[63:32], w_div_quot_nxt};
    end else begin
      w_acc_step = w_mul_acc;
    end
`else
    w_acc_step = w_mul_acc;
`endif
  end

  // Result selection and sign restoration on the final iteration.
  always_comb begin
    if (r_sign == 1'b1) begin
      w_prod = f_neg64(w_acc_step);
    end else begin
      w_prod = w_acc_step;
    end
    case (r_funct3)
      F3_MUL:                       w_final_result = w_prod[31:0];
      F3_MULH, F3_MULHSU, F3_MULHU: w_final_result = w_prod[63:32];
`ifdef MULDIV_DIV_EN
      F3_DIV, F3_DIVU: begin
        if (r_sign == 1'b1) begin
          w_final_result = f_neg32(w_acc_step[31:0]);
        end else begin
          w_final_result = w_acc_step[31:0];
        end
      end
      F3_REM, F3_REMU: begin
        if (r_sign == 1'b1) begin
          w_final_result = f_neg32(w_div_rem_nxt[31:0]);
        end else begin
          w_final_result = w_div_rem_nxt[31:0];
        end
      end
`endif
      default: w_final_result = 32'd0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          if (w_special) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_CALC;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CALC: begin
        if (i_ex_jump_flag) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_CALC;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand capture at acceptance and per-cycle iteration of the datapath.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_funct3      <= 3'd0;
      r_sign        <= 1'b0;
      r_cnt         <= 5'd0;
      r_acc         <= 64'd0;
      r_mcand       <= 32'd0;
      r_result      <= 32'd0;
      r_reg_wr_addr <= 6'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_funct3      <= w_funct3;
            r_reg_wr_addr <= i_reg_wr_addr;
            r_sign        <= w_op_sign;
            r_cnt         <= 5'd0;
            r_acc         <= {32'd0, w_op_a};
            r_mcand       <= w_op_b;
            if (w_special) begin
              r_result <= w_special_result;
            end
          end
        end
        S_CALC: begin
          if (!i_ex_jump_flag) begin
            r_acc <= w_acc_step;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == CNT_LAST) begin
              r_result <= w_final_result;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef MULDIV_DIV_EN
  // Partial remainder of the restoring divider.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rem <= 33'd0;
    end else if ((r_state == S_IDLE) && w_start) begin
      r_rem <= 33'd0;
    end else if ((r_state == S_CALC) && !i_ex_jump_flag && (r_funct3[2] == 1'b1)) begin
      r_rem <= w_div_rem_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_ex_muldiv.sv
// ---------------------------------------------------------------------------
// tb_ex_muldiv -- directed self-checking bench for ex_muldiv.
// Cycle 1 is the cycle in which the instruction is presented. Inputs change
// 1 time unit after a rising edge, and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_ex_muldiv;

  logic        clk;
  logic        rst;
  logic [31:0] i_inst;
  logic [31:0] i_op1;
  logic [31:0] i_op2;
  logic [5:0]  i_reg_wr_addr;
  logic        i_ex_jump_flag;
  logic        o_busy;
  logic        o_valid;
  logic [31:0] o_result;
  logic        o_reg_we;
  logic [5:0]  o_reg_wr_addr;

  int checks;
  int failures;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  rd;
    logic [31:0] exp;
    int          cyc;
  } vec_t;

  ex_muldiv dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_inst         (i_inst),
    .i_op1          (i_op1),
    .i_op2          (i_op2),
    .i_reg_wr_addr  (i_reg_wr_addr),
    .i_ex_jump_flag (i_ex_jump_flag),
    .o_busy         (o_busy),
    .o_valid        (o_valid),
    .o_result       (o_result),
    .o_reg_we       (o_reg_we),
    .o_reg_wr_addr  (o_reg_wr_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk_inst(input logic [2:0] f3, input logic [5:0] rd);
    mk_inst = {7'b0000001, 5'd2, 5'd1, f3, rd[4:0], 7'b0110011};
  endfunction

  // Presents one instruction in cycle 1, then scrambles every input so that
  // late operand changes would show up, and records 40 cycles of outputs.
  task automatic run_op(input vec_t v, output int vcyc, output int vcount,
                        output logic [31:0] res, output logic [5:0] rd_o,
                        output int busy_bad, output int we_bad);
    logic exp_busy;
    vcyc = 0; vcount = 0; res = 32'd0; rd_o = 6'd0; busy_bad = 0; we_bad = 0;
    i_inst = mk_inst(v.f3, v.rd); i_op1 = v.a; i_op2 = v.b; i_reg_wr_addr = v.rd;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      exp_busy = (cyc < v.cyc);
      if (o_busy !== exp_busy) busy_bad++;
      if (o_reg_we !== o_valid) we_bad++;
      if (o_valid === 1'b1) begin
        vcount++;
        if (vcount == 1) begin
          vcyc = cyc; res = o_result; rd_o = o_reg_wr_addr;
        end
      end
      @(posedge clk); #1;
      if (cyc == 1) begin
        i_inst = NOP_INST; i_op1 = ~v.a; i_op2 = ~v.b; i_reg_wr_addr = ~v.rd;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_inst = mk_inst(3'b000, 6'd5); i_op1 = 32'd3; i_op2 = 32'd4; i_reg_wr_addr = 6'd5;
    i_ex_jump_flag = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset busy: got %b want 0", o_busy); end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset valid: got %b want 0", o_valid); end
    checks++; if (o_reg_we !== 1'b0) begin failures++; $display("FAIL reset we: got %b want 0", o_reg_we); end
    checks++; if (o_result !== 32'd0) begin failures++; $display("FAIL reset result: got %h want 0", o_result); end
    checks++; if (o_reg_wr_addr !== 6'd0) begin failures++; $display("FAIL reset rd: got %h want 0", o_reg_wr_addr); end
    @(posedge clk); #1;
    rst = 1'b0; i_inst = NOP_INST;
    @(negedge clk);
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL idle nop busy: got %b want 0", o_busy); end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL idle nop valid: got %b want 0", o_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    vec_t v [6];
    int vcyc, vcount, busy_bad, we_bad;
    logic [31:0] res;
    logic [5:0]  rd_o;
    v[0] = '{3'b000, 32'd7,          32'hFFFF_FFFD, 6'h2A, 32'hFFFF_FFEB, 34};
    v[1] = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'h01, 32'hFFFF_FFFE, 34};
    v[2] = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'h1F, 32'h0000_0000, 34};
    v[3] = '{3'b010, 32'hFFFF_FFFF, 32'd2,          6'h10, 32'hFFFF_FFFF, 34};
    v[4] = '{3'b001, 32'h8000_0000, 32'd2,          6'h33, 32'hFFFF_FFFF, 34};
    v[5] = '{3'b000, 32'h1234_5678, 32'h0000_0010, 6'h03, 32'h2345_6780, 34};
    for (int i = 0; i < 6; i++) begin
      run_op(v[i], vcyc, vcount, res, rd_o, busy_bad, we_bad);
      checks++; if (vcyc != v[i].cyc) begin failures++; $display("FAIL mul[%0d] valid cycle: got %0d want %0d", i, vcyc, v[i].cyc); end
      checks++; if (vcount != 1) begin failures++; $display("FAIL mul[%0d] valid count: got %0d want 1", i, vcount); end
      checks++; if (res !== v[i].exp) begin failures++; $display("FAIL mul[%0d] result: got %h want %h", i, res, v[i].exp); end
      checks++; if (rd_o !== v[i].rd) begin failures++; $display("FAIL mul[%0d] rd: got %h want %h", i, rd_o, v[i].rd); end
      checks++; if (busy_bad != 0) begin failures++; $display("FAIL mul[%0d] busy pattern: got %0d bad cycles want 0", i, busy_bad); end
      checks++; if (we_bad != 0) begin failures++; $display("FAIL mul[%0d] we==valid: got %0d bad cycles want 0", i, we_bad); end
    end
  endtask

`ifdef MULDIV_DIV_EN
  task automatic test_div();
    vec_t v [5];
    int vcyc, vcount, busy_bad, we_bad;
    logic [31:0] res;
    logic [5:0]  rd_o;
    v[0] = '{3'b101, 32'd100,        32'd7, 6'h04, 32'd14,         34};
    v[1] = '{3'b111, 32'd100,        32'd7, 6'h05, 32'd2,          34};
    v[2] = '{3'b100, 32'hFFFF_FF9C, 32'd7, 6'h06, 32'hFFFF_FFF2, 34};
    v[3] = '{3'b110, 32'hFFFF_FF9C, 32'd7, 6'h27, 32'hFFFF_FFFE, 34};
    v[4] = '{3'b101, 32'hFFFF_FFFF, 32'd1, 6'h08, 32'hFFFF_FFFF, 34};
    for (int i = 0; i < 5; i++) begin
      run_op(v[i], vcyc, vcount, res, rd_o, busy_bad, we_bad);
      checks++; if (vcyc != v[i].cyc) begin failures++; $display("FAIL div[%0d] valid cycle: got %0d want %0d", i, vcyc, v[i].cyc); end
      checks++; if (vcount != 1) begin failures++; $display("FAIL div[%0d] valid count: got %0d want 1", i, vcount); end
      checks++; if (res !== v[i].exp) begin failures++; $display("FAIL div[%0d] result: got %h want %h", i, res, v[i].exp); end
      checks++; if (rd_o !== v[i].rd) begin failures++; $display("FAIL div[%0d] rd: got %h want %h", i, rd_o, v[i].rd); end
      checks++; if (busy_bad != 0) begin failures++; $display("FAIL div[%0d] busy pattern: got %0d bad cycles want 0", i, busy_bad); end
      checks++; if (we_bad != 0) begin failures++; $display("FAIL div[%0d] we==valid: got %0d bad cycles want 0", i, we_bad); end
    end
  endtask

  task automatic test_special();
    vec_t v [6];
    int vcyc, vcount, busy_bad, we_bad;
    logic [31:0] res;
    logic [5:0]  rd_o;
    v[0] = '{3'b100, 32'd5,          32'd0,          6'h09, 32'hFFFF_FFFF, 2};
    v[1] = '{3'b110, 32'd5,          32'd0,          6'h0A, 32'd5,          2};
    v[2] = '{3'b101, 32'd5,          32'd0,          6'h0B, 32'hFFFF_FFFF, 2};
    v[3] = '{3'b111, 32'd9,          32'd0,          6'h2C, 32'd9,          2};
    v[4] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 6'h0D, 32'h8000_0000, 2};
    v[5] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 6'h0E, 32'd0,          2};
    for (int i = 0; i < 6; i++) begin
      run_op(v[i], vcyc, vcount, res, rd_o, busy_bad, we_bad);
      checks++; if (vcyc != v[i].cyc) begin failures++; $display("FAIL special[%0d] valid cycle: got %0d want %0d", i, vcyc, v[i].cyc); end
      checks++; if (vcount != 1) begin failures++; $display("FAIL special[%0d] valid count: got %0d want 1", i, vcount); end
      checks++; if (res !== v[i].exp) begin failures++; $display("FAIL special[%0d] result: got %h want %h", i, res, v[i].exp); end
      checks++; if (rd_o !== v[i].rd) begin failures++; $display("FAIL special[%0d] rd: got %h want %h", i, rd_o, v[i].rd); end
      checks++; if (busy_bad != 0) begin failures++; $display("FAIL special[%0d] busy pattern: got %0d bad cycles want 0", i, busy_bad); end
    end
  endtask
`else
  task automatic test_div_disabled();
    int busy_hi, valid_hi, vcyc, vcount, busy_bad, we_bad;
    logic [31:0] res;
    logic [5:0]  rd_o;
    vec_t mv;
    busy_hi = 0; valid_hi = 0;
    i_inst = mk_inst(3'b101, 6'd4); i_op1 = 32'd100; i_op2 = 32'd7; i_reg_wr_addr = 6'd4;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (o_busy !== 1'b0) busy_hi++;
      if (o_valid !== 1'b0) valid_hi++;
      @(posedge clk); #1;
      if (cyc == 20) i_inst = mk_inst(3'b110, 6'd4);
    end
    i_inst = NOP_INST;
    checks++; if (busy_hi != 0) begin failures++; $display("FAIL nodiv busy: got %0d busy cycles want 0", busy_hi); end
    checks++; if (valid_hi != 0) begin failures++; $display("FAIL nodiv valid: got %0d valid cycles want 0", valid_hi); end
    mv = '{3'b000, 32'd3, 32'd4, 6'h12, 32'd12, 34};
    run_op(mv, vcyc, vcount, res, rd_o, busy_bad, we_bad);
    checks++; if (vcyc != 34) begin failures++; $display("FAIL nodiv mul cycle: got %0d want 34", vcyc); end
    checks++; if (res !== 32'd12) begin failures++; $display("FAIL nodiv mul result: got %h want 0000000c", res); end
  endtask
`endif

  task automatic test_flush();
    int busy_bad, vcount, vcyc, busy_b2, we_bad;
    logic exp_busy;
    logic [31:0] res;
    logic [5:0]  rd_o;
    vec_t mv;
    busy_bad = 0; vcount = 0;
    i_inst = mk_inst(3'b000, 6'd9); i_op1 = 32'd7; i_op2 = 32'd5; i_reg_wr_addr = 6'd9;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      exp_busy = (cyc <= 10);
      if (o_busy !== exp_busy) busy_bad++;
      if (o_valid === 1'b1) vcount++;
      @(posedge clk); #1;
      if (cyc == 1) i_inst = NOP_INST;
      if (cyc == 9) i_ex_jump_flag = 1'b1;
      if (cyc == 10) i_ex_jump_flag = 1'b0;
    end
    checks++; if (busy_bad != 0) begin failures++; $display("FAIL flush busy pattern: got %0d bad cycles want 0", busy_bad); end
    checks++; if (vcount != 0) begin failures++; $display("FAIL flush valid: got %0d valid cycles want 0", vcount); end
    // Unit must accept a fresh operation after the abort.
    mv = '{3'b000, 32'd9, 32'd9, 6'h15, 32'd81, 34};
    run_op(mv, vcyc, vcount, res, rd_o, busy_b2, we_bad);
    checks++; if (vcyc != 34) begin failures++; $display("FAIL post-flush cycle: got %0d want 34", vcyc); end
    checks++; if (res !== 32'd81) begin failures++; $display("FAIL post-flush result: got %h want 00000051", res); end
  endtask

  task automatic test_flush_at_start();
    int busy_hi, valid_hi;
    busy_hi = 0; valid_hi = 0;
    i_inst = mk_inst(3'b000, 6'd2); i_op1 = 32'd2; i_op2 = 32'd2; i_reg_wr_addr = 6'd2;
    i_ex_jump_flag = 1'b1;
    @(negedge clk);
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL flush-at-start busy: got %b want 0", o_busy); end
    @(posedge clk); #1;
    i_inst = NOP_INST; i_ex_jump_flag = 1'b0;
    for (int cyc = 2; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (o_busy !== 1'b0) busy_hi++;
      if (o_valid !== 1'b0) valid_hi++;
      @(posedge clk); #1;
    end
    checks++; if ((busy_hi + valid_hi) != 0) begin failures++; $display("FAIL flush-at-start activity: got %0d busy %0d valid want 0 0", busy_hi, valid_hi); end
  endtask

  task automatic test_reset_mid();
    int busy_bad, vcount;
    busy_bad = 0; vcount = 0;
    i_inst = mk_inst(3'b000, 6'h21); i_op1 = 32'h1234; i_op2 = 32'h10; i_reg_wr_addr = 6'h21;
    for (int cyc = 1; cyc <= 19; cyc++) begin
      @(negedge clk);
      if (o_busy !== 1'b1) busy_bad++;
      @(posedge clk); #1;
      if (cyc == 1) i_inst = NOP_INST;
    end
    checks++; if (busy_bad != 0) begin failures++; $display("FAIL rstmid busy before: got %0d bad cycles want 0", busy_bad); end
    rst = 1'b1;
    #1;
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL rstmid busy: got %b want 0", o_busy); end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL rstmid valid: got %b want 0", o_valid); end
    checks++; if (o_result !== 32'd0) begin failures++; $display("FAIL rstmid result: got %h want 0", o_result); end
    checks++; if (o_reg_wr_addr !== 6'd0) begin failures++; $display("FAIL rstmid rd: got %h want 0", o_reg_wr_addr); end
    @(posedge clk); #1;
    rst = 1'b0;
    busy_bad = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (o_busy !== 1'b0) busy_bad++;
      if (o_valid === 1'b1) vcount++;
      @(posedge clk); #1;
    end
    checks++; if (busy_bad != 0) begin failures++; $display("FAIL rstmid busy after: got %0d bad cycles want 0", busy_bad); end
    checks++; if (vcount != 0) begin failures++; $display("FAIL rstmid valid after: got %0d valid cycles want 0", vcount); end
  endtask

  // Instruction held continuously: the DONE cycle must not accept, and the
  // second operation starts in cycle 35 with the operands present then.
  task automatic test_back_to_back();
    int busy_bad, vcount, v1, v2;
    logic [31:0] r1, r2;
    logic exp_busy;
    busy_bad = 0; vcount = 0; v1 = 0; v2 = 0; r1 = 32'd0; r2 = 32'd0;
    i_inst = mk_inst(3'b000, 6'd7); i_op1 = 32'd5; i_op2 = 32'd6; i_reg_wr_addr = 6'd7;
    for (int cyc = 1; cyc <= 68; cyc++) begin
      @(negedge clk);
      exp_busy = (cyc <= 33) || ((cyc >= 35) && (cyc <= 67));
      if (o_busy !== exp_busy) busy_bad++;
      if (o_valid === 1'b1) begin
        vcount++;
        if (vcount == 1) begin v1 = cyc; r1 = o_result; end
        else begin v2 = cyc; r2 = o_result; end
      end
      @(posedge clk); #1;
      if (cyc == 1) i_op1 = 32'd6;
      if (cyc == 68) i_inst = NOP_INST;
    end
    checks++; if (vcount != 2) begin failures++; $display("FAIL b2b valid count: got %0d want 2", vcount); end
    checks++; if (v1 != 34) begin failures++; $display("FAIL b2b first cycle: got %0d want 34", v1); end
    checks++; if (r1 !== 32'd30) begin failures++; $display("FAIL b2b first result: got %h want 0000001e", r1); end
    checks++; if (v2 != 68) begin failures++; $display("FAIL b2b second cycle: got %0d want 68", v2); end
    checks++; if (r2 !== 32'd36) begin failures++; $display("FAIL b2b second result: got %h want 00000024", r2); end
    checks++; if (busy_bad != 0) begin failures++; $display("FAIL b2b busy pattern: got %0d bad cycles want 0", busy_bad); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; i_inst = NOP_INST; i_op1 = 32'd0; i_op2 = 32'd0;
    i_reg_wr_addr = 6'd0; i_ex_jump_flag = 1'b0;
    test_reset();
    test_mul();
`ifdef MULDIV_DIV_EN
    test_div();
    test_special();
`else
    test_div_disabled();
`endif
    test_flush();
    test_flush_at_start();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
